dmem_access_unit: RTL

Load/store unit between the MEM stage of the dynamic pipeline and the word-wide data memory. It turns pipeline load/store requests (byte, halfword, word; signed or unsigned) into word accesses on the data-memory port. Loads are returned extracted and extended. Byte and halfword stores run as a two-cycle read-modify-write, with a stall to the pipeline. Misaligned accesses are flagged and never touch memory.

---
 rtl/dmem_access_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_access_unit.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Sub-word stores are a two-cycle read-modify-write; misaligned requests never reach memory.
module dmem_access_unit #(
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              busy,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              addr_err,
   output logic              dmem_ena,
   output logic              dmem_wena,
   output logic              dmem_rena,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata
);

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_R = 2'b11;

   typedef enum logic {IDLE, RMW_WR} state_e;

   state_e            state_q;
   logic              busy_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_rdata_q;
   logic              addr_err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       merge_q;

   logic              accept;
   logic              misalign;
   logic              sub_store;
   logic [ADDR_W-1:0] req_word;
   logic [4:0]        lane_shift;
   logic [31:0]       shifted;
   logic [31:0]       load_ext;
   logic [31:0]       lane_mask;
   logic [31:0]       lane_data;
   logic [31:0]       merged;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

   assign req_word   = req_addr[ADDR_W+1:2];
   assign lane_shift = {req_addr[1:0], 3'b000};
   assign accept     = req_valid && (state_q == IDLE);
   assign sub_store  = req_we && (req_size != SZ_W);
   assign misalign   = (req_size == SZ_R)
                    || ((req_size == SZ_H) && req_addr[0])
                    || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));

   // Extract the addressed lane and extend it to a full word
   always_comb begin
      shifted  = dmem_rdata >> lane_shift;
      load_ext = dmem_rdata;
      case (req_size)
         SZ_B: load_ext = req_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H: load_ext = req_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = dmem_rdata;
      endcase
   end

   // Replace the target lane of the word just read with the store data
   always_comb begin
      lane_mask = 32'h0;
      lane_data = 32'h0;
      if (req_size == SZ_B) begin
         lane_mask = 32'h0000_00ff << lane_shift;
         lane_data = {24'h0, req_wdata[7:0]} << lane_shift;
      end else begin
         lane_mask = 32'h0000_ffff << lane_shift;
         lane_data = {16'h0, req_wdata[15:0]} << lane_shift;
      end
      merged = (dmem_rdata & ~lane_mask) | (lane_data & lane_mask);
   end

   // Memory port: write-back of the merged word in RMW_WR, otherwise the accepted request
   always_comb begin
      dmem_ena   = 1'b0;
      dmem_wena  = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = 32'h0;
      if (rst_n) begin
         if (state_q == RMW_WR) begin
            dmem_ena   = 1'b1;
            dmem_wena  = 1'b1;
            dmem_addr  = addr_q;
            dmem_wdata = merge_q;
         end else if (accept && !misalign) begin
            dmem_ena  = 1'b1;
            dmem_wena = req_we && (req_size == SZ_W);
            dmem_addr = req_word;
            if (dmem_wena) dmem_wdata = req_wdata;
         end
      end
      dmem_rena = dmem_ena && !dmem_wena;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         addr_err_q  <= 1'b0;
         addr_q      <= '0;
         merge_q     <= 32'h0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         addr_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (!misalign && sub_store) begin
                     state_q <= RMW_WR;
                     busy_q  <= 1'b1;
                     addr_q  <= req_word;
                     merge_q <= merged;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     addr_err_q  <= misalign;
                     rsp_rdata_q <= (!misalign && !req_we) ? load_ext : 32'h0;
                  end
               end
            end
            RMW_WR: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               rsp_valid_q <= 1'b1;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign addr_err  = addr_err_q;

endmodule
